// File: rtl/fetch_buffer_pkg.sv
// Shared types for the IF/ID fetch buffer: fetch payload, pipe control and stored entry.
package fetch_buffer_pkg;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic        enable;
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_info_t;

  typedef struct packed {
    logic stall;
    logic flush;
  } pipe_ctrl_t;

  typedef struct packed {
    fetch_info_t info;
    logic        error;
  } fetch_entry_t;

  // True when the free space left after this cycle can no longer absorb the in-flight fetches.
  function automatic logic stall_needed(input int unsigned depth,
                                        input int unsigned count,
                                        input int unsigned slack);
    return (depth - count) <= slack;
  endfunction

endpackage

// File: rtl/fetch_buffer_mem.sv
// Entry storage for the fetch buffer: one write port, one asynchronous read port, no reset.
module fetch_buffer_mem
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         i_we,
  input  logic [AW-1:0] i_waddr,
  input  fetch_entry_t i_wdata,
  input  logic [AW-1:0] i_raddr,
  output fetch_entry_t o_rdata
);

  fetch_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_buffer.sv
// IF/ID decoupling queue: in-order valid/ready delivery to decode, early stall toward fetch,
// flush with wrong-path kill window, and error lock that stops pushes after a faulting fetch.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int IN_FLIGHT   = 2,
  parameter int KILL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  fetch_info_t in_info,
  input  logic        in_error,
  input  pipe_ctrl_t  pipe,
  output logic        fetch_stall,
  output logic        out_valid,
  output fetch_info_t out_info,
  output logic        out_error,
  input  logic        out_ready,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int KW = (KILL_CYCLES > 0) ? $clog2(KILL_CYCLES + 1) : 1;
  localparam logic [PW-1:0] DEPTH_P   = PW'(DEPTH);
  localparam logic [KW-1:0] KILL_INIT = KW'(KILL_CYCLES);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [KW-1:0] r_kill;
  logic          r_err_lock;
  logic          r_stall;
  logic          r_overflow;

  logic [PW-1:0] w_wr_ptr_nxt;
  logic [PW-1:0] w_rd_ptr_nxt;
  logic [PW-1:0] w_count;
  logic [PW-1:0] w_count_nxt;
  logic [KW-1:0] w_kill_nxt;
  logic          w_err_lock_nxt;
  logic          w_stall_nxt;
  logic          w_overflow_nxt;
  logic          w_empty;
  logic          w_full;
  logic          w_push_req;
  logic          w_pop;
  logic          w_write;
  logic          w_drop;
  fetch_entry_t  w_wr_entry;
  fetch_entry_t  w_rd_entry;

  // Occupancy is the pointer difference; the extra pointer bit separates full from empty.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == DEPTH_P);

  assign w_push_req = in_info.enable && (r_kill == '0) && !r_err_lock && !pipe.flush;
  assign w_pop      = !w_empty && out_ready && !pipe.stall && !pipe.flush;
  assign w_write    = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  always_comb begin
    w_wr_ptr_nxt   = r_wr_ptr;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_kill_nxt     = r_kill;
    w_err_lock_nxt = r_err_lock;
    if (pipe.flush) begin
      w_wr_ptr_nxt   = '0;
      w_rd_ptr_nxt   = '0;
      w_kill_nxt     = KILL_INIT;
      w_err_lock_nxt = 1'b0;
    end else begin
      if (w_write) begin
        w_wr_ptr_nxt = r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + PW'(1);
      end
      if (r_kill != '0) begin
        w_kill_nxt = r_kill - KW'(1);
      end
      if (w_write && in_error) begin
        w_err_lock_nxt = 1'b1;
      end
    end
    w_count_nxt    = w_wr_ptr_nxt - w_rd_ptr_nxt;
    w_stall_nxt    = stall_needed(32'(DEPTH), 32'(w_count_nxt), 32'(IN_FLIGHT));
    w_overflow_nxt = r_overflow | w_drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_kill     <= '0;
      r_err_lock <= 1'b0;
      r_stall    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_kill     <= w_kill_nxt;
      r_err_lock <= w_err_lock_nxt;
      r_stall    <= w_stall_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  assign w_wr_entry = {in_info, in_error};

  fetch_buffer_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_write),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (w_wr_entry),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rd_entry)
  );

  // Only enabled fetches are stored, so the stored enable bit already equals out_valid.
  assign out_valid = !w_empty;

  always_comb begin
    out_info  = '0;
    out_error = 1'b0;
    if (out_valid) begin
      out_info  = w_rd_entry.info;
      out_error = w_rd_entry.error;
    end
  end

  assign fetch_stall = r_stall;
  assign overflow    = r_overflow;

endmodule
